// File: rtl/binary_search_engine_if.sv
// Bus bundle for binary_search_engine: search request/result handshake,
// the synchronous memory read port, and the FSM state for observation.
//
// Handshake: a request is accepted on a rising clock edge where start=1 while
// the engine is idle (busy=0, done=0); target/lo_in/hi_in are captured on that
// same edge and may change freely afterwards. start in any other cycle is
// ignored. done is a one-cycle pulse marking found/index/probes valid; those
// outputs then hold until the next accepted request.
interface binary_search_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [DATA_W-1:0] target;
    logic [ADDR_W-1:0] lo_in;
    logic [ADDR_W-1:0] hi_in;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_q;
    logic              busy;
    logic              done;
    logic              found;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W:0]   probes;
    logic [2:0]        fsm_state;

    // Engine side.
    modport slave (
        input  start, target, lo_in, hi_in, mem_q,
        output mem_addr, mem_rd, busy, done, found, index, probes, fsm_state
    );

    // Requester plus memory side.
    modport master (
        output start, target, lo_in, hi_in, mem_q,
        input  mem_addr, mem_rd, busy, done, found, index, probes, fsm_state
    );
endinterface

// File: rtl/binary_search_engine.sv
// Binary search over a sorted synchronous memory between caller-supplied
// bounds. One probe costs MEM_LAT+1 cycles (issue, wait, compare). The
// pointers carry one extra bit so L may step to 2**ADDR_W without wrapping;
// R never goes below zero because a "target is smaller" result at M==0 ends
// the search instead of computing M-1.
module binary_search_engine #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 5,
    parameter int MEM_LAT    = 1,
    parameter bit DESCENDING = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    binary_search_engine_if.slave  bus
);
    localparam int PTR_W = ADDR_W + 1;
    localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] target_q;
    logic [PTR_W-1:0]  l_q;
    logic [PTR_W-1:0]  r_q;
    logic [PTR_W-1:0]  m_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              found_q;
    logic [ADDR_W-1:0] index_q;
    logic [PTR_W-1:0]  probes_q;

    logic [PTR_W:0]    sum;
    logic [PTR_W-1:0]  mid;
    logic              range_empty;
    logic              hit;
    logic              go_left;

    // Midpoint and compare results; sum has a spare bit so L+R never wraps.
    always_comb begin
        sum         = {1'b0, l_q} + {1'b0, r_q};
        mid         = PTR_W'(sum >> 1);
        range_empty = (l_q > r_q);
        hit         = (bus.mem_q == target_q);
        go_left     = DESCENDING ? (target_q > bus.mem_q) : (target_q < bus.mem_q);
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (range_empty) begin
                    state_next = S_DONE;
                end else if (MEM_LAT == 1) begin
                    state_next = S_COMPARE;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (hit) begin
                    state_next = S_DONE;
                end else if (go_left && (m_q == '0)) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_ISSUE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: request capture, pointer narrowing and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            target_q <= '0;
            l_q      <= '0;
            r_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            found_q  <= 1'b0;
            index_q  <= '0;
            probes_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        target_q <= bus.target;
                        l_q      <= {1'b0, bus.lo_in};
                        r_q      <= {1'b0, bus.hi_in};
                        probes_q <= '0;
                        found_q  <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (!range_empty) begin
                        m_q   <= mid;
                        cnt_q <= '0;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_COMPARE: begin
                    probes_q <= probes_q + PTR_ONE;
                    index_q  <= m_q[ADDR_W-1:0];
                    if (hit) begin
                        found_q <= 1'b1;
                    end else if (go_left) begin
                        if (m_q != '0) begin
                            r_q <= m_q - PTR_ONE;
                        end
                    end else begin
                        l_q <= m_q + PTR_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state; the read address is live only while issuing.
    always_comb begin
        bus.mem_rd    = (state == S_ISSUE) && !range_empty;
        bus.mem_addr  = (state == S_ISSUE) ? mid[ADDR_W-1:0] : m_q[ADDR_W-1:0];
        bus.busy      = (state == S_ISSUE) || (state == S_WAIT) || (state == S_COMPARE);
        bus.done      = (state == S_DONE);
        bus.found     = found_q;
        bus.index     = index_q;
        bus.probes    = probes_q;
        bus.fsm_state = state;
    end
endmodule

// File: tb/tb_binary_search_engine.sv
// Bench for binary_search_engine: two instances (read latency 1 and 3) over a
// memory holding mem[i] = 2*i. Drivers push expected results, done cycles and
// probe addresses into queues; per-instance monitors pop and compare whenever
// the DUT strobes mem_rd or done.
module tb_binary_search_engine;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int RW = 1 + AW + AW + 1;

    logic clock;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    binary_search_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
    binary_search_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus3 ();

    binary_search_engine #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(1), .DESCENDING(1'b0)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1)
    );
    binary_search_engine #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(3), .DESCENDING(1'b0)) dut3 (
        .clock(clock), .reset(reset), .bus(bus3)
    );

    // Scoreboard queues: {found, index, probes}, done cycle, probe addresses.
    logic [RW-1:0] exp_q1[$];
    logic [RW-1:0] exp_q3[$];
    int            exp_cyc1[$];
    int            exp_cyc3[$];
    logic [AW-1:0] exp_addr1[$];
    logic [AW-1:0] exp_addr3[$];

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- memory models ----------------
    // Latency 1: registered read; junk whenever no read was issued.
    always @(posedge clock) begin
        if (bus1.mem_rd) bus1.mem_q <= DW'({bus1.mem_addr, 1'b0});
        else             bus1.mem_q <= DW'($urandom);
    end

    // Latency 3: two pipeline stages then the output register.
    logic          v3a, v3b;
    logic [AW-1:0] a3a, a3b;
    always @(posedge clock) begin
        v3a <= bus3.mem_rd;
        a3a <= bus3.mem_addr;
        v3b <= v3a;
        a3b <= a3a;
        if (v3b) bus3.mem_q <= DW'({a3b, 1'b0});
        else     bus3.mem_q <= DW'($urandom);
    end

    // ---------------- monitors ----------------
    logic          prev_done1, prev_done3;
    logic [RW-1:0] got1, want1, got3, want3;
    logic [AW-1:0] wa1, wa3;
    int            wc1, wc3;

    always @(negedge clock) begin
        if (!reset) begin
            if (bus1.mem_rd) begin
                checks++;
                if (exp_addr1.size() == 0) begin
                    errors++;
                    $display("FAIL probe_addr1 unexpected mem_rd got addr=%0d want no read", bus1.mem_addr);
                end else begin
                    wa1 = exp_addr1.pop_front();
                    if (bus1.mem_addr !== wa1) begin
                        errors++;
                        $display("FAIL probe_addr1 got %0d want %0d", bus1.mem_addr, wa1);
                    end
                end
            end
            if (bus1.done) begin
                checks++;
                if (prev_done1) begin
                    errors++;
                    $display("FAIL done_width1 done high two cycles in a row at cycle %0d", cyc);
                end
                if (exp_q1.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done1 got done at cycle %0d want none", cyc);
                end else begin
                    want1 = exp_q1.pop_front();
                    wc1   = exp_cyc1.pop_front();
                    got1  = {bus1.found, bus1.index, bus1.probes};
                    if (got1 !== want1) begin
                        errors++;
                        $display("FAIL result1 got found=%0b index=%0d probes=%0d want found=%0b index=%0d probes=%0d",
                                 got1[RW-1], got1[RW-2 -: AW], got1[AW:0], want1[RW-1], want1[RW-2 -: AW], want1[AW:0]);
                    end
                    checks++;
                    if (cyc != wc1) begin
                        errors++;
                        $display("FAIL done_cycle1 got %0d want %0d", cyc, wc1);
                    end
                end
            end
        end
        prev_done1 = bus1.done;
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (bus3.mem_rd) begin
                checks++;
                if (exp_addr3.size() == 0) begin
                    errors++;
                    $display("FAIL probe_addr3 unexpected mem_rd got addr=%0d want no read", bus3.mem_addr);
                end else begin
                    wa3 = exp_addr3.pop_front();
                    if (bus3.mem_addr !== wa3) begin
                        errors++;
                        $display("FAIL probe_addr3 got %0d want %0d", bus3.mem_addr, wa3);
                    end
                end
            end
            if (bus3.done) begin
                checks++;
                if (prev_done3) begin
                    errors++;
                    $display("FAIL done_width3 done high two cycles in a row at cycle %0d", cyc);
                end
                if (exp_q3.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done3 got done at cycle %0d want none", cyc);
                end else begin
                    want3 = exp_q3.pop_front();
                    wc3   = exp_cyc3.pop_front();
                    got3  = {bus3.found, bus3.index, bus3.probes};
                    if (got3 !== want3) begin
                        errors++;
                        $display("FAIL result3 got found=%0b index=%0d probes=%0d want found=%0b index=%0d probes=%0d",
                                 got3[RW-1], got3[RW-2 -: AW], got3[AW:0], want3[RW-1], want3[RW-2 -: AW], want3[AW:0]);
                    end
                    checks++;
                    if (cyc != wc3) begin
                        errors++;
                        $display("FAIL done_cycle3 got %0d want %0d", cyc, wc3);
                    end
                end
            end
        end
        prev_done3 = bus3.done;
    end

    // ---------------- driver tasks ----------------
    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Issue one request on the latency-1 instance; lat = cycles from start to done.
    task automatic search1(input logic [AW-1:0] lo, input logic [AW-1:0] hi, input logic [DW-1:0] tgt,
                           input logic ef, input logic [AW-1:0] ei, input logic [AW:0] ep, input int lat);
        @(negedge clock);
        bus1.start  = 1'b1;
        bus1.target = tgt;
        bus1.lo_in  = lo;
        bus1.hi_in  = hi;
        exp_q1.push_back({ef, ei, ep});
        exp_cyc1.push_back(cyc + lat);
        @(negedge clock);
        bus1.start  = 1'b0;
        bus1.target = DW'($urandom);
        bus1.lo_in  = AW'($urandom);
        bus1.hi_in  = AW'($urandom);
    endtask

    task automatic search3(input logic [AW-1:0] lo, input logic [AW-1:0] hi, input logic [DW-1:0] tgt,
                           input logic ef, input logic [AW-1:0] ei, input logic [AW:0] ep, input int lat);
        @(negedge clock);
        bus3.start  = 1'b1;
        bus3.target = tgt;
        bus3.lo_in  = lo;
        bus3.hi_in  = hi;
        exp_q3.push_back({ef, ei, ep});
        exp_cyc3.push_back(cyc + lat);
        @(negedge clock);
        bus3.start  = 1'b0;
        bus3.target = DW'($urandom);
        bus3.lo_in  = AW'($urandom);
        bus3.hi_in  = AW'($urandom);
    endtask

    // Wait, bounded, until every expected response has been seen.
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q1.size() + exp_q3.size() + exp_addr1.size() + exp_addr3.size()) != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL timeout_%s got %0d results %0d addrs pending want 0",
                     name, exp_q1.size() + exp_q3.size(), exp_addr1.size() + exp_addr3.size());
            exp_q1.delete(); exp_q3.delete(); exp_cyc1.delete(); exp_cyc3.delete();
            exp_addr1.delete(); exp_addr3.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cyc = 0; checks = 0; errors = 0;
        prev_done1 = 1'b0; prev_done3 = 1'b0;
        bus1.start = 1'b0; bus1.target = '0; bus1.lo_in = '0; bus1.hi_in = '0;
        bus3.start = 1'b0; bus3.target = '0; bus3.lo_in = '0; bus3.hi_in = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset state.
        check_val("rst_busy1",   int'(bus1.busy),   0);
        check_val("rst_done1",   int'(bus1.done),   0);
        check_val("rst_found1",  int'(bus1.found),  0);
        check_val("rst_index1",  int'(bus1.index),  0);
        check_val("rst_probes1", int'(bus1.probes), 0);
        check_val("rst_mem_rd1", int'(bus1.mem_rd), 0);
        check_val("rst_addr1",   int'(bus1.mem_addr), 0);
        check_val("rst_state3",  int'(bus3.fsm_state), 0);

        // Latency 1: hit in the middle.
        exp_addr1.push_back(15); exp_addr1.push_back(7); exp_addr1.push_back(11);
        exp_addr1.push_back(9);  exp_addr1.push_back(10);
        search1(0, 31, 20, 1'b1, 10, 5, 11);
        drain("hit20");

        // Miss between entries: L steps past R after the last probe.
        exp_addr1.push_back(15); exp_addr1.push_back(7); exp_addr1.push_back(11);
        exp_addr1.push_back(9);  exp_addr1.push_back(10);
        search1(0, 31, 21, 1'b0, 10, 5, 12);
        drain("miss21");

        // Top entry, then one past it: L reaches 32 and must not wrap.
        exp_addr1.push_back(15); exp_addr1.push_back(23); exp_addr1.push_back(27);
        exp_addr1.push_back(29); exp_addr1.push_back(30); exp_addr1.push_back(31);
        search1(0, 31, 62, 1'b1, 31, 6, 13);
        drain("hit62");
        exp_addr1.push_back(15); exp_addr1.push_back(23); exp_addr1.push_back(27);
        exp_addr1.push_back(29); exp_addr1.push_back(30); exp_addr1.push_back(31);
        search1(0, 31, 63, 1'b0, 31, 6, 14);
        drain("miss63");

        // Empty range: no reads, index keeps the previous value.
        search1(5, 4, 7, 1'b0, 31, 0, 2);
        drain("empty");

        // Low end of memory and a single-entry range.
        exp_addr1.push_back(15); exp_addr1.push_back(7); exp_addr1.push_back(3); exp_addr1.push_back(1);
        search1(0, 31, 2, 1'b1, 1, 4, 9);
        drain("hit2");
        exp_addr1.push_back(9);
        search1(9, 9, 18, 1'b1, 9, 1, 3);
        drain("single");

        // start pulsed while busy is ignored.
        exp_addr1.push_back(15); exp_addr1.push_back(7); exp_addr1.push_back(11);
        exp_addr1.push_back(9);  exp_addr1.push_back(10);
        search1(0, 31, 20, 1'b1, 10, 5, 11);
        @(negedge clock);
        bus1.start = 1'b1; bus1.target = 40; bus1.lo_in = 3; bus1.hi_in = 4;
        @(negedge clock);
        bus1.start = 1'b0;
        drain("busy_start");

        // Latency 3.
        exp_addr3.push_back(15);
        search3(0, 31, 30, 1'b1, 15, 1, 5);
        drain("lat3_hit30");
        exp_addr3.push_back(15); exp_addr3.push_back(7); exp_addr3.push_back(11);
        exp_addr3.push_back(9);  exp_addr3.push_back(10);
        search3(0, 31, 20, 1'b1, 10, 5, 21);
        drain("lat3_hit20");
        exp_addr3.push_back(15); exp_addr3.push_back(7); exp_addr3.push_back(11);
        exp_addr3.push_back(9);  exp_addr3.push_back(10);
        search3(0, 31, 21, 1'b0, 10, 5, 22);
        drain("lat3_miss21");

        // Reset while waiting on memory aborts with no done.
        @(negedge clock);
        bus3.start = 1'b1; bus3.target = 30; bus3.lo_in = 0; bus3.hi_in = 31;
        exp_addr3.push_back(15);
        @(negedge clock);
        bus3.start = 1'b0;
        @(negedge clock);
        check_val("wait_state3", int'(bus3.fsm_state), 2);
        check_val("wait_busy3",  int'(bus3.busy), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_val("abort_busy3",   int'(bus3.busy),   0);
        check_val("abort_mem_rd3", int'(bus3.mem_rd), 0);
        check_val("abort_done3",   int'(bus3.done),   0);
        check_val("abort_probes3", int'(bus3.probes), 0);
        check_val("abort_found3",  int'(bus3.found),  0);
        repeat (20) @(negedge clock);
        check_val("abort_no_done3", int'(exp_q3.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
